// File: rtl/gray_pkg.sv
// Shared gray-code helpers and default sizing for the pointer crossing.
package gray_pkg;

    localparam int unsigned GRAY_PTR_WIDTH   = 4;
    localparam int unsigned GRAY_SYNC_STAGES = 2;

    // Widest pointer the helpers handle. Narrower pointers are zero-extended,
    // which leaves both conversions exact for the low bits.
    localparam int unsigned GRAY_MAX_WIDTH   = 32;

    // Binary to reflected gray code.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Gray to binary, resolved MSB to LSB as a running XOR.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b = '0;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = int'(GRAY_MAX_WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer for a gray-coded bus. Used by both FIFO sides.
module gray_sync_chain
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH  = GRAY_PTR_WIDTH,
    parameter int unsigned STAGES = GRAY_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Read-side receiver of a gray-coded remote pointer: synchronize, decode,
// and derive fill level / empty against the local binary pointer.
// Optional multi-bit-step checker enabled by defining GRAY_PTR_CHECK_EN.
module gray_ptr_receiver
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH       = GRAY_PTR_WIDTH,
    parameter int unsigned SYNC_STAGES = GRAY_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic [WIDTH-1:0] local_bin,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic             updated,
    output logic [WIDTH-1:0] level,
    output logic             empty,
    output logic             gray_err
);

    logic [WIDTH-1:0] bin_dec;

    gray_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (gray_in),
        .dout  (gray_sync)
    );

    assign bin_dec = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_sync)));

    // Register the decoded pointer and flag every change of value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
            updated <= 1'b0;
        end else begin
            bin_out <= bin_dec;
            updated <= (bin_dec != bin_out);
        end
    end

    // Live local pointer makes a local advance visible the same cycle.
    assign level = bin_out - local_bin;
    assign empty = (bin_out == local_bin);

`ifdef GRAY_PTR_CHECK_EN
    logic [WIDTH-1:0] prev_sync;
    logic             multi_step;

    assign multi_step = ($countones(gray_sync ^ prev_sync) > 1);

    // Sticky flag for a synchronized gray value moving more than one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sync <= '0;
            gray_err  <= 1'b0;
        end else begin
            prev_sync <= gray_sync;
            if (multi_step) begin
                gray_err <= 1'b1;
            end
        end
    end
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Self-checking bench for gray_ptr_receiver (default WIDTH=4, SYNC_STAGES=2).
module tb_gray_ptr_receiver;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;
`ifdef GRAY_PTR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] local_bin = '0;
    logic [W-1:0] gray_sync, bin_out, level;
    logic         updated, empty, gray_err;

    int vectors = 0;
    int miscompares = 0;

    gray_ptr_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .local_bin (local_bin),
        .gray_sync (gray_sync),
        .bin_out   (bin_out),
        .updated   (updated),
        .level     (level),
        .empty     (empty),
        .gray_err  (gray_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // hist holds gray_in as seen at each rising edge since reset, newest last.
    logic [W-1:0] hist [$];
    bit           m_err = 1'b0;

    function automatic logic [W-1:0] ago(int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    // Inverse of gray encoding found by search over all codes.
    function automatic logic [W-1:0] dec(logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            if (W'(b ^ (b >> 1)) == g) return W'(b);
        end
        return '0;
    endfunction

    function automatic int pop(logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < int'(W); i++) n += int'(x[i]);
        return n;
    endfunction

    always @(negedge rst_n) begin
        hist.delete();
        m_err = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            hist.push_back(gray_in);
            if (hist.size() > 16) void'(hist.pop_front());
            if (CHK && pop(ago(S) ^ ago(S + 1)) > 1) m_err = 1'b1;
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare process: every falling edge, DUT against the model.
    always @(negedge clk) begin
        logic [W-1:0] eb;
        eb = dec(ago(S));
        chk("m_gray_sync", int'(gray_sync), int'(ago(S - 1)));
        chk("m_bin_out",   int'(bin_out),   int'(eb));
        chk("m_updated",   int'(updated),   int'(eb != dec(ago(S + 1))));
        chk("m_level",     int'(level),     int'(W'(eb - local_bin)));
        chk("m_empty",     int'(empty),     int'(eb == local_bin));
        chk("m_gray_err",  int'(gray_err),  int'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gray_in = '0;
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_gray_sync", int'(gray_sync), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_updated", int'(updated), 0);
        chk("rst_gray_err", int'(gray_err), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_level", int'(level), 0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // First value: gray 0001 appears on bin_out three edges later.
        gray_in = 4'b0001;
        @(negedge clk); chk("t1_bin_e1", int'(bin_out), 0);
        @(negedge clk); chk("t1_sync_e2", int'(gray_sync), 1);
        chk("t1_bin_e2", int'(bin_out), 0);
        @(negedge clk);
        chk("t1_bin_e3", int'(bin_out), 1);
        chk("t1_upd_e3", int'(updated), 1);
        chk("t1_level_e3", int'(level), 1);
        chk("t1_empty_e3", int'(empty), 0);
        @(negedge clk); chk("t1_upd_e4", int'(updated), 0);
        #1;

        // Full lap 0..15 then wrap to 0, one step per two cycles.
        for (int b = 0; b <= 16; b++) begin
            cnt = W'(b);
            gray_in = cnt ^ (cnt >> 1);
            step(2);
        end
        step(3);
        chk("lap_bin_wrap", int'(bin_out), 0);
        chk("lap_err", int'(gray_err), 0);

        // Level against a stepping local pointer with bin_out = 5.
        gray_in = 4'b0111;
        local_bin = 4'd3;
        step(4);
        chk("lvl_bin5", int'(bin_out), 5);
        chk("lvl_3", int'(level), 2);
        chk("lvl_3_empty", int'(empty), 0);
        local_bin = 4'd4; #1;
        chk("lvl_4", int'(level), 1);
        local_bin = 4'd5; #1;
        chk("lvl_5", int'(level), 0);
        chk("lvl_5_empty", int'(empty), 1);
        step(1);

        // Randomized legal stream, random local pointer.
        cnt = 4'd5;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) cnt = cnt + 4'd1;
            gray_in = cnt ^ (cnt >> 1);
            local_bin = W'($urandom);
            step(1);
        end
        chk("rnd_err", int'(gray_err), 0);

        // Illegal two-bit jump 0000 -> 0011.
        local_bin = '0;
        do_reset();
        step(2);
        gray_in = 4'b0011;
        step(2);
        @(negedge clk);
        chk("bad_bin", int'(bin_out), 2);
        chk("bad_err", int'(gray_err), int'(CHK));
        step(5);
        chk("bad_err_hold", int'(gray_err), int'(CHK));

        // Random stream with occasional illegal jumps.
        do_reset();
        cnt = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 60) == 0) cnt = W'($urandom);
            else if ($urandom_range(0, 1) == 0) cnt = cnt + 4'd1;
            gray_in = cnt ^ (cnt >> 1);
            local_bin = W'($urandom);
            step(1);
        end

        // Asynchronous reset with bin_out = 9, then recovery.
        local_bin = '0;
        do_reset();
        gray_in = 4'b1101;
        step(4);
        chk("mid_bin9", int'(bin_out), 9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sync", int'(gray_sync), 0);
        chk("mid_rst_bin", int'(bin_out), 0);
        chk("mid_rst_upd", int'(updated), 0);
        chk("mid_rst_err", int'(gray_err), 0);
        chk("mid_rst_empty", int'(empty), 1);
        step(2);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("rel_bin_e2", int'(bin_out), 0);
        @(negedge clk);
        chk("rel_bin_e3", int'(bin_out), 9);
        chk("rel_upd_e3", int'(updated), 1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
